// File: rtl/change_dispenser.sv
// Change dispenser: pays back a nickel-unit amount one coin at a time,
// largest coin first, over a req/ack handshake with the coin ejector.
//
// Ports: clk, rst (sync, active-high); start/amount from vend control;
// q_empty/d_empty/n_empty tube status; eject_ack from ejector;
// eject_q/eject_d/eject_n coin requests; busy, done, short, remaining,
// fault status back to vend control.
// Optional macro CHG_TIMEOUT_EN adds an ack timeout of TMO cycles.
module change_dispenser #(
  parameter int         n   = 6,
  parameter logic [7:0] TMO = 8'd255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [n-1:0] amount,
  input  logic         q_empty,
  input  logic         d_empty,
  input  logic         n_empty,
  input  logic         eject_ack,
  output logic         eject_q,
  output logic         eject_d,
  output logic         eject_n,
  output logic         busy,
  output logic         done,
  output logic         short,
  output logic [n-1:0] remaining,
  output logic         fault
);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    EJECT,
    RELEASE,
    FINISH
  } state_t;

  state_t       state, state_nx;
  logic [n-1:0] rem_nx;
  logic [n-1:0] coin;
  logic         q_nx, d_nx, n_nx;
  logic         short_nx;

`ifdef CHG_TIMEOUT_EN
  logic [7:0] cnt, cnt_nx;
  logic       fault_nx;
`else
  logic [7:0] unused_tmo;
  assign unused_tmo = TMO;
  assign fault      = 1'b0;
`endif

  // Value of the coin currently being requested.
  always_comb begin
    coin = n'(1);
    if (eject_q)      coin = n'(5);
    else if (eject_d) coin = n'(2);
  end

  always_comb begin
    state_nx = state;
    rem_nx   = remaining;
    q_nx     = eject_q;
    d_nx     = eject_d;
    n_nx     = eject_n;
    short_nx = short;
`ifdef CHG_TIMEOUT_EN
    cnt_nx   = cnt;
    fault_nx = fault;
`endif
    unique case (state)
      IDLE: begin
        if (start) begin
          rem_nx   = amount;
          short_nx = 1'b0;
`ifdef CHG_TIMEOUT_EN
          fault_nx = 1'b0;
`endif
          state_nx = SELECT;
        end
      end
      SELECT: begin
`ifdef CHG_TIMEOUT_EN
        cnt_nx = 8'd0;
`endif
        if (remaining == '0) begin
          state_nx = FINISH;
        end else if (remaining >= n'(5) && !q_empty) begin
          q_nx     = 1'b1;
          state_nx = EJECT;
        end else if (remaining >= n'(2) && !d_empty) begin
          d_nx     = 1'b1;
          state_nx = EJECT;
        end else if (!n_empty) begin
          n_nx     = 1'b1;
          state_nx = EJECT;
        end else begin
          short_nx = 1'b1;
          state_nx = FINISH;
        end
      end
      EJECT: begin
        if (eject_ack) begin
          q_nx     = 1'b0;
          d_nx     = 1'b0;
          n_nx     = 1'b0;
          rem_nx   = remaining - coin;
          state_nx = RELEASE;
`ifdef CHG_TIMEOUT_EN
        end else if (cnt == TMO - 8'd1) begin
          // Ejector never answered: give up, amount stays owed.
          q_nx     = 1'b0;
          d_nx     = 1'b0;
          n_nx     = 1'b0;
          short_nx = 1'b1;
          fault_nx = 1'b1;
          state_nx = FINISH;
        end else begin
          cnt_nx = cnt + 8'd1;
`endif
        end
      end
      RELEASE: begin
        // Next request only after the previous ack has dropped.
        if (!eject_ack) state_nx = SELECT;
      end
      FINISH: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      eject_q   <= 1'b0;
      eject_d   <= 1'b0;
      eject_n   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      short     <= 1'b0;
      remaining <= '0;
`ifdef CHG_TIMEOUT_EN
      cnt       <= 8'd0;
      fault     <= 1'b0;
`endif
    end else begin
      state     <= state_nx;
      eject_q   <= q_nx;
      eject_d   <= d_nx;
      eject_n   <= n_nx;
      busy      <= (state_nx != IDLE);
      done      <= (state_nx == FINISH);
      short     <= short_nx;
      remaining <= rem_nx;
`ifdef CHG_TIMEOUT_EN
      cnt       <= cnt_nx;
      fault     <= fault_nx;
`endif
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Testbench for change_dispenser: directed and random change-return
// operations checked against a greedy coin-payout reference model.
module tb_change_dispenser;

  localparam int N = 6;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] amount = '0;
  logic         q_empty = 1'b0;
  logic         d_empty = 1'b0;
  logic         n_empty = 1'b0;
  logic         eject_ack = 1'b0;
  logic         eject_q, eject_d, eject_n;
  logic         busy, done, short, fault;
  logic [N-1:0] remaining;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_coins[$];

  change_dispenser #(.n(N), .TMO(8'd4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .amount    (amount),
    .q_empty   (q_empty),
    .d_empty   (d_empty),
    .n_empty   (n_empty),
    .eject_ack (eject_ack),
    .eject_q   (eject_q),
    .eject_d   (eject_d),
    .eject_n   (eject_n),
    .busy      (busy),
    .done      (done),
    .short     (short),
    .remaining (remaining),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Greedy payout with tube fallback; fills exp_coins.
  task automatic model(input int amt, input bit qe, input bit de,
                       input bit ne, output int r, output bit sh);
    int c;
    exp_coins.delete();
    r  = amt;
    sh = 1'b0;
    while (r > 0) begin
      if (r >= 5 && !qe)      c = 5;
      else if (r >= 2 && !de) c = 2;
      else if (!ne)           c = 1;
      else                    c = 0;
      if (c == 0) begin
        sh = 1'b1;
        break;
      end
      exp_coins.push_back(c);
      r -= c;
    end
  endtask

  task automatic run_op(input int amt, input bit qe, input bit de,
                        input bit ne, input int dly, input bit poke,
                        input bit noack);
    int  got[$];
    int  iter, ack_cnt, qhigh, exp_rem, first, cn;
    bit  seen, fin, exp_sh, exp_flt;
    model(amt, qe, de, ne, exp_rem, exp_sh);
    exp_flt = 1'b0;
    if (noack) begin
      first = exp_coins[0];
      exp_coins.delete();
      exp_coins.push_back(first);
      exp_rem = amt;
      exp_sh  = 1'b1;
      exp_flt = 1'b1;
    end
    @(negedge clk);
    start   = 1'b1;
    amount  = N'(amt);
    q_empty = qe;
    d_empty = de;
    n_empty = ne;
    iter = 0; seen = 0; fin = 0; ack_cnt = 0; qhigh = 0;
    while (!fin && iter < 300) begin
      @(negedge clk);
      iter++;
      chk("onehot", int'($countones({eject_q, eject_d, eject_n}) <= 1), 1);
      chk("busy", busy, 1);
      if (eject_q | eject_d | eject_n) begin
        if (!seen) begin
          seen = 1;
          got.push_back(eject_q ? 5 : eject_d ? 2 : 1);
          ack_cnt = 0;
        end
        qhigh++;
        if (!noack && !eject_ack) begin
          if (ack_cnt == dly) eject_ack = 1'b1;
          else ack_cnt++;
        end
      end else if (eject_ack) begin
        eject_ack = 1'b0;
        seen = 0;
      end
      if (done) fin = 1;
      start = poke && iter == 3 && !fin;
      if (start) amount = N'(5);
    end
    start = 1'b0;
    chk("budget", fin, 1);
    cn = got.size() < exp_coins.size() ? got.size() : exp_coins.size();
    chk("ncoins", got.size(), exp_coins.size());
    for (int i = 0; i < cn; i++) chk("coin", got[i], exp_coins[i]);
    chk("short", short, exp_sh);
    chk("remaining", remaining, exp_rem);
    chk("fault", fault, exp_flt);
    if (amt == 0) chk("lat0", iter, 2);
    if (noack) chk("tmo_len", qhigh, 4);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("busy_drop", busy, 0);
    chk("rem_hold", remaining, exp_rem);
    chk("short_hold", short, exp_sh);
    eject_ack = 1'b0;
  endtask

  task automatic reset_mid_eject();
    int  k;
    bit  hit;
    @(negedge clk);
    start   = 1'b1;
    amount  = N'(8);
    q_empty = 0; d_empty = 0; n_empty = 0;
    hit = 0;
    for (k = 0; k < 10 && !hit; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (eject_q | eject_d | eject_n) hit = 1;
    end
    chk("rst_reach", hit, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_out", int'({eject_q, eject_d, eject_n, busy, done, short,
                         fault, remaining}), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_idle", int'({busy, eject_q, eject_d, eject_n}), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_state", int'({eject_q, eject_d, eject_n, busy, done, short,
                             fault, remaining}), 0);
    rst = 1'b0;
    run_op(8, 0, 0, 0, 1, 0, 0);
    run_op(8, 1, 0, 0, 0, 0, 0);
    run_op(3, 0, 0, 1, 0, 0, 0);
    run_op(0, 0, 0, 0, 0, 0, 0);
    run_op(13, 0, 0, 0, 2, 1, 0);
    run_op(7, 1, 1, 1, 0, 0, 0);
    run_op(63, 0, 1, 0, 0, 0, 0);
    reset_mid_eject();
`ifdef CHG_TIMEOUT_EN
    run_op(5, 0, 0, 0, 0, 0, 1);
`endif
    for (int i = 0; i < 40; i++) begin
      run_op($urandom_range(0, 63),
             $urandom_range(0, 3) == 0,
             $urandom_range(0, 3) == 0,
             $urandom_range(0, 3) == 0,
             $urandom_range(0, 2),
             $urandom_range(0, 1) == 1,
             0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
